rambam_decoder: RTL and testbench

Serial RAMBAM decoder. It takes a masked element in the redundant ring F2[x]/(P·Q), a vector of 8+d coefficients, and reduces it modulo P to recover the plain GF(2^8) byte. Reduction is one long-division step per cycle, and the result is handed off with a drdy-style pulse. It sits at the output boundary of the masked datapath, downstream of the serial multiplier, and uses the same drdy_i/drdy_o handshake and coefficient ordering.

---
 rtl/rambam_pkg.sv | 32 +++
 rtl/rambam_reduce_step.sv | 25 ++
 rtl/rambam_decoder.sv | 114 +++++++++++
 tb/tb_rambam_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rambam_pkg.sv
// Shared RAMBAM definitions: redundancy degree, field and
// redundant-ring polynomials, element type and decoder FSM states.
package rambam_pkg;

  localparam int D = 8;

  // bit i = coefficient of x^i
  localparam logic [0:8] P = 9'b110110001;
  localparam logic [0:D] Q = 9'b101110001;

  function automatic logic [0:8+D] pmul(
    input logic [0:8] a,
    input logic [0:D] b
  );
    logic [0:8+D] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j <= D; j++)
        r[i+j] = r[i+j] ^ (a[i] & b[j]);
    return r;
  endfunction

  localparam logic [0:8+D] PQ = pmul(P, Q);

  typedef logic [0:7+D] elem_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

endpackage

// File: rtl/rambam_reduce_step.sv
// One long-division step: if rem[8+k] is set, XOR (P << k) in.
// Ports: i_rem working remainder, i_k step index, o_rem result.
module rambam_reduce_step #(
  parameter int         d = rambam_pkg::D,
  parameter logic [0:8] P = rambam_pkg::P
) (
  input  logic [0:7+d]           i_rem,
  input  logic [$clog2(d+1)-1:0] i_k,
  output logic [0:7+d]           o_rem
);
  import rambam_pkg::*;

  localparam int KW = $clog2(d + 1);

  always_comb begin
    o_rem = i_rem;
    for (int k = 0; k < d; k++) begin
      if (i_k == KW'(k) && i_rem[8+k]) begin
        for (int j = 0; j < 9; j++)
          o_rem[j+k] = o_rem[j+k] ^ P[j];
      end
    end
  end

endmodule

// File: rtl/rambam_decoder.sv
// Serial RAMBAM decoder: reduces a masked element modulo P.
// Ports: clk, rst, drdy_i/y in; out, drdy_o, busy, ovf out.
module rambam_decoder #(
  parameter int         d = rambam_pkg::D,
  parameter logic [0:8] P = rambam_pkg::P
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic [0:7+d] y,
  output logic [0:7]   out,
  output logic         drdy_o,
  output logic         busy,
  output logic         ovf
);
  import rambam_pkg::*;

  localparam int CW = $clog2(d + 1);
  localparam logic [CW-1:0] LAST = CW'(d - 1);

  fsm_t          r_state;
  fsm_t          w_next;
  logic [0:7+d]  r_rem;
  logic [0:7+d]  r_buf;
  logic [0:7+d]  w_step;
  logic          r_buf_v;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_k;
  logic          w_done;
  logic [0:7]    r_out;
  logic          r_drdy_o;
  logic          r_ovf;

  // steps run from the top coefficient downward
  assign w_k    = LAST - r_cnt;
  assign w_done = (r_state == RUN) && (r_cnt == LAST);

  rambam_reduce_step #(
    .d (d),
    .P (P)
  ) u_step (
    .i_rem (r_rem),
    .i_k   (w_k),
    .o_rem (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (drdy_i) w_next = RUN;
      RUN:  if (w_done && !r_buf_v && !drdy_i)
              w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == RUN);
    out    = r_out;
    drdy_o = r_drdy_o;
    ovf    = r_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_buf    <= '0;
      r_buf_v  <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_drdy_o <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_drdy_o <= 1'b0;
      if (r_state == IDLE) begin
        if (drdy_i) begin
          r_rem <= y;
          r_cnt <= '0;
        end
      end else if (w_done) begin
        r_out    <= w_step[0:7];
        r_drdy_o <= 1'b1;
        r_cnt    <= '0;
        if (r_buf_v) begin
          r_rem   <= r_buf;
          r_buf_v <= drdy_i;
          if (drdy_i) r_buf <= y;
        end else if (drdy_i) begin
          r_rem <= y;
        end else begin
          // no masked residue left behind when idle
          r_rem <= '0;
        end
      end else begin
        r_rem <= w_step;
        r_cnt <= r_cnt + 1'b1;
        if (drdy_i) begin
          if (!r_buf_v) begin
            r_buf   <= y;
            r_buf_v <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rambam_decoder.sv
// Self-checking bench for rambam_decoder (d = 8, P = 0x11B).
// Timestamp-based transaction model checked every cycle.
module tb_rambam_decoder;

  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         drdy_i;
  logic [0:7+D] y;
  logic [0:7]   out;
  logic         drdy_o;
  logic         busy;
  logic         ovf;

  always #5 clk = ~clk;

  rambam_decoder #(.d(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .drdy_i (drdy_i),
    .y      (y),
    .out    (out),
    .drdy_o (drdy_o),
    .busy   (busy),
    .ovf    (ovf)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          cyc_n;
  bit          m_busy;
  int          m_done;
  logic [15:0] m_cur;
  logic [15:0] m_buf;
  bit          m_buf_v;
  logic [7:0]  e_out;
  bit          e_drdy;
  bit          e_ovf;
  bit          chk_en = 1'b0;

  // polynomial remainder modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] pmod(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int b = 15; b >= 8; b--)
      if (t[b]) t = t ^ (16'h011B << (b - 8));
    return t[7:0];
  endfunction

  function automatic logic [15:0] clmul(input logic [7:0] r);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (r[i]) p = p ^ (16'h011B << i);
    return p;
  endfunction

  function automatic logic [7:0] out_val(input logic [0:7] o);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = o[i];
    return v;
  endfunction

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc_n   = 0;
    m_busy  = 0;
    m_done  = 0;
    m_cur   = '0;
    m_buf   = '0;
    m_buf_v = 0;
    e_out   = '0;
    e_drdy  = 0;
    e_ovf   = 0;
  endtask

  // one clock edge of the transaction-level model
  task automatic model_edge(input bit dv, input logic [15:0] yv);
    cyc_n++;
    e_drdy = 0;
    if (m_busy && cyc_n == m_done) begin
      e_drdy = 1;
      e_out  = pmod(m_cur);
      if (m_buf_v) begin
        m_cur   = m_buf;
        m_done  = cyc_n + D;
        m_buf_v = dv;
        if (dv) m_buf = yv;
      end else if (dv) begin
        m_cur  = yv;
        m_done = cyc_n + D;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy) begin
      if (dv) begin
        if (!m_buf_v) begin
          m_buf   = yv;
          m_buf_v = 1;
        end else begin
          e_ovf = 1;
        end
      end
    end else if (dv) begin
      m_busy = 1;
      m_cur  = yv;
      m_done = cyc_n + D;
    end
  endtask

  task automatic tick(input bit dv, input logic [15:0] yv);
    drdy_i = dv;
    for (int i = 0; i < 16; i++) y[i] = yv[i];
    @(posedge clk);
    model_edge(dv, yv);
    #1;
    drdy_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("drdy_o", drdy_o, e_drdy);
      check("busy", busy, m_busy);
      check("ovf", ovf, e_ovf);
      check("out", out_val(out), e_out);
    end
  end

  task automatic do_reset(input string nm);
    rst = 1'b1;
    model_reset();
    #1;
    check({nm, "_rst_out"}, out_val(out), 0);
    check({nm, "_rst_drdy"}, drdy_o, 0);
    check({nm, "_rst_busy"}, busy, 0);
    check({nm, "_rst_ovf"}, ovf, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_one(input logic [15:0] yv,
                         input logic [7:0] exp,
                         input string nm);
    int n;
    int busy_n;
    bit got;
    n = 0;
    busy_n = 0;
    got = 0;
    tick(1, yv);
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) busy_n++;
      tick(0, 16'h0);
      n++;
      if (drdy_o) got = 1;
    end
    check({nm, "_latency"}, n, D);
    check({nm, "_busy_cycles"}, busy_n, D);
    check({nm, "_out"}, out_val(out), exp);
  endtask

  initial begin
    int edges[$];
    logic [7:0] outs[$];
    int n;
    int seen;
    logic [7:0] a;
    logic [7:0] r;
    logic [15:0] yv;
    int gap;

    rst    = 1'b1;
    drdy_i = 1'b0;
    y      = '0;

    check("pin_mod_148", pmod(16'h0148), 8'h53);
    check("pin_mod_11b", pmod(16'h011B), 8'h00);
    check("pin_clmul_1", clmul(8'h01), 16'h011B);
    check("pin_clmul_3", clmul(8'h03), 16'h032D);

    do_reset("init");
    chk_en = 1'b1;

    // passthrough and masked r = 1
    run_one(16'h0053, 8'h53, "t1");
    run_one(16'h0148, 8'h53, "t2a");
    run_one(16'h011B, 8'h00, "t2b");

    // random masks, spaced so the buffer never overflows
    for (int v = 0; v < 1000; v++) begin
      a  = 8'($urandom_range(0, 255));
      r  = 8'($urandom_range(0, 255));
      yv = {8'h00, a} ^ clmul(r);
      if (v < 4) check("t3_model_pin", pmod(yv), a);
      tick(1, yv);
      gap = $urandom_range(D, D + 3);
      repeat (gap) tick(0, 16'h0);
      check("t3_out", out_val(out), a);
    end
    check("t3_ovf", ovf, 0);

    // chaining through buf plus one dropped input
    do_reset("t4");
    tick(1, 16'h0148);
    tick(0, 16'h0);
    tick(0, 16'h0);
    tick(1, 16'h0053);
    tick(1, 16'h0077);
    check("t4_ovf_set", ovf, 1);
    for (int e = 5; e <= 24; e++) begin
      tick(0, 16'h0);
      if (drdy_o) begin
        edges.push_back(e);
        outs.push_back(out_val(out));
      end
    end
    check("t4_n_results", edges.size(), 2);
    if (edges.size() == 2) begin
      check("t4_edge0", edges[0], 8);
      check("t4_edge1", edges[1], 16);
      check("t4_out0", outs[0], 8'h53);
      check("t4_out1", outs[1], 8'h53);
    end
    check("t4_ovf_sticky", ovf, 1);

    // new input on the completion edge with buf empty
    do_reset("t5");
    tick(1, 16'h0148);
    repeat (D - 1) tick(0, 16'h0);
    tick(1, 16'h01DC);
    check("t5_first_drdy", drdy_o, 1);
    check("t5_first_out", out_val(out), 8'h53);
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick(0, 16'h0);
      n++;
      if (drdy_o) seen = 1;
    end
    check("t5_gap", n, D);
    check("t5_second_out", out_val(out), 8'hC7);

    // reset mid-run
    do_reset("t6a");
    tick(1, 16'h0148);
    repeat (4) tick(0, 16'h0);
    do_reset("t6b");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 16'h0);
      if (drdy_o) seen++;
    end
    check("t6_no_drdy", seen, 0);
    run_one(16'h0148, 8'h53, "t6c");

    // random traffic with chaining and overflow
    do_reset("t7");
    for (int i = 0; i < 2000; i++) begin
      yv = 16'($urandom_range(0, 65535));
      tick($urandom_range(0, 5) == 0, yv);
    end
    repeat (2 * D + 2) tick(0, 16'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
